// File: rtl/ppi_sync_core.sv
// Clock-synchronous 8255-style PPI: PA/PB/PC, control word, BSR, split pins.
// Optional Mode 1 strobed handshake on Port A when PPI_MODE1_EN is defined.
module ppi_sync_core #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] RESET_CW    = 8'h9B
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       CS_N,
  input  logic       RD_N,
  input  logic       WR_N,
  input  logic [1:0] A,
  input  logic [7:0] DIN,
  output logic [7:0] DOUT,
  output logic       DOE,
  input  logic [7:0] PA_IN,
  input  logic [7:0] PB_IN,
  input  logic [7:0] PC_IN,
  output logic [7:0] PA_OUT,
  output logic [7:0] PB_OUT,
  output logic [7:0] PC_OUT,
  output logic [7:0] PA_OE,
  output logic [7:0] PB_OE,
  output logic [7:0] PC_OE
);

  localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

  logic [7:0] pa_s [NS];
  logic [7:0] pb_s [NS];
  logic [7:0] pc_s [NS];
  logic [7:0] pa_sync, pb_sync, pc_sync;

  logic [7:0] ctrl;
  logic [7:0] pa_lat, pb_lat, pc_lat;
  logic       wr_n_q;

  logic       rd_act, wr_stb;
  logic       wr_pa, wr_pb, wr_pc, wr_cw, wr_bsr;
  logic       bsr_inte;

  logic       m1_in, m1_out;
  logic       ibf, obf_n, intr, inte;
  logic [7:0] pa_hold;

  logic [7:0] hs_mask, hs_oe, hs_val, rd_hs_val;
  logic [7:0] pc_dir_out, pc_wmask;
  logic [7:0] pa_rd, pb_rd, pc_rd, rd_data;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < NS; i++) begin
        pa_s[i] <= '0;
        pb_s[i] <= '0;
        pc_s[i] <= '0;
      end
    end else begin
      pa_s[0] <= PA_IN;
      pb_s[0] <= PB_IN;
      pc_s[0] <= PC_IN;
      for (int i = 1; i < NS; i++) begin
        pa_s[i] <= pa_s[i-1];
        pb_s[i] <= pb_s[i-1];
        pc_s[i] <= pc_s[i-1];
      end
    end
  end

  assign pa_sync = pa_s[NS-1];
  assign pb_sync = pb_s[NS-1];
  assign pc_sync = pc_s[NS-1];

  // One write per WR_N strobe: only the falling cycle commits
  assign rd_act = ~CS_N & ~RD_N;
  assign wr_stb = ~CS_N & ~WR_N & wr_n_q;
  assign wr_pa  = wr_stb & (A == 2'b00);
  assign wr_pb  = wr_stb & (A == 2'b01);
  assign wr_pc  = wr_stb & (A == 2'b10);
  assign wr_cw  = wr_stb & (A == 2'b11) & DIN[7];
  assign wr_bsr = wr_stb & (A == 2'b11) & ~DIN[7];

  assign bsr_inte = (m1_in  & (DIN[3:1] == 3'd4))
                  | (m1_out & (DIN[3:1] == 3'd6));

`ifdef PPI_MODE1_EN
  logic stb_q, ack_q, rd_pa_q;
  logic stb_fall, stb_rise, ack_fall, ack_rise, rd_done;

  assign m1_in  = (ctrl[6:5] == 2'b01) & ctrl[4];
  assign m1_out = (ctrl[6:5] == 2'b01) & ~ctrl[4];

  assign stb_fall = stb_q & ~pc_sync[4];
  assign stb_rise = ~stb_q & pc_sync[4];
  assign ack_fall = ack_q & ~pc_sync[6];
  assign ack_rise = ~ack_q & pc_sync[6];
  assign rd_done  = rd_pa_q & RD_N;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      stb_q   <= 1'b1;
      ack_q   <= 1'b1;
      rd_pa_q <= 1'b0;
    end else begin
      stb_q   <= pc_sync[4];
      ack_q   <= pc_sync[6];
      rd_pa_q <= rd_act & (A == 2'b00);
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET || wr_cw) begin
      ibf     <= 1'b0;
      intr    <= 1'b0;
      inte    <= 1'b0;
      obf_n   <= 1'b1;
      pa_hold <= '0;
    end else begin
      if (wr_bsr && bsr_inte)
        inte <= DIN[0];
      if (m1_in) begin
        // A new strobe beats a read completing in the same cycle
        if (stb_fall) begin
          pa_hold <= pa_sync;
          ibf     <= 1'b1;
        end else if (rd_done) begin
          ibf <= 1'b0;
        end
        if (rd_done)
          intr <= 1'b0;
        else if (stb_rise && ibf && inte)
          intr <= 1'b1;
      end else if (m1_out) begin
        if (wr_pa) begin
          obf_n <= 1'b0;
          intr  <= 1'b0;
        end else begin
          if (ack_fall)
            obf_n <= 1'b1;
          if (ack_rise && inte)
            intr <= 1'b1;
        end
      end
    end
  end
`else
  assign m1_in   = 1'b0;
  assign m1_out  = 1'b0;
  assign ibf     = 1'b0;
  assign obf_n   = 1'b1;
  assign intr    = 1'b0;
  assign inte    = 1'b0;
  assign pa_hold = '0;
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      ctrl   <= RESET_CW;
      pa_lat <= '0;
      pb_lat <= '0;
      pc_lat <= '0;
      wr_n_q <= 1'b1;
    end else begin
      wr_n_q <= WR_N;
      if (wr_cw) begin
        ctrl   <= DIN;
        pa_lat <= '0;
        pb_lat <= '0;
        pc_lat <= '0;
      end else begin
        if (wr_pa)
          pa_lat <= DIN;
        if (wr_pb)
          pb_lat <= DIN;
        if (wr_pc)
          pc_lat <= (pc_lat & ~pc_wmask) | (DIN & pc_wmask);
        if (wr_bsr && !bsr_inte)
          pc_lat[DIN[3:1]] <= DIN[0];
      end
    end
  end

  always_comb begin
    hs_mask = 8'h00;
    hs_oe   = 8'h00;
    if (m1_in) begin
      hs_mask = 8'b0011_1000;
      hs_oe   = 8'b0010_1000;
    end else if (m1_out) begin
      hs_mask = 8'b1100_1000;
      hs_oe   = 8'b1000_1000;
    end
  end

  assign pc_dir_out = {{4{~ctrl[3]}}, {4{~ctrl[0]}}};
  assign pc_wmask   = pc_dir_out & ~hs_mask;
  assign hs_val     = {obf_n, 1'b0, ibf, 1'b0, intr, 3'b000};
  assign rd_hs_val  = {obf_n, inte, ibf, inte, intr, 3'b000};

  assign PA_OUT = pa_lat;
  assign PB_OUT = pb_lat;
  assign PC_OUT = (pc_lat & ~hs_oe) | (hs_val & hs_oe);
  assign PA_OE  = {8{~ctrl[4]}};
  assign PB_OE  = {8{~ctrl[1]}};
  assign PC_OE  = pc_wmask | hs_oe;

  assign pa_rd = m1_in ? pa_hold : (ctrl[4] ? pa_sync : pa_lat);
  assign pb_rd = ctrl[1] ? pb_sync : pb_lat;
  assign pc_rd = (((pc_dir_out & pc_lat) | (~pc_dir_out & pc_sync)) & ~hs_mask)
               | (rd_hs_val & hs_mask);

  always_comb begin
    rd_data = ctrl;
    unique case (A)
      2'b00:   rd_data = pa_rd;
      2'b01:   rd_data = pb_rd;
      2'b10:   rd_data = pc_rd;
      default: rd_data = ctrl;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      DOUT <= '0;
      DOE  <= 1'b0;
    end else begin
      DOE <= rd_act;
      if (rd_act)
        DOUT <= rd_data;
    end
  end

endmodule

// File: tb/tb_ppi_sync_core.sv
// Directed self-checking bench for ppi_sync_core.
// Mode 1 scenarios run only when PPI_MODE1_EN is defined.
module tb_ppi_sync_core;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       CS_N, RD_N, WR_N;
  logic [1:0] A;
  logic [7:0] DIN;
  logic [7:0] DOUT;
  logic       DOE;
  logic [7:0] PA_IN, PB_IN, PC_IN;
  logic [7:0] PA_OUT, PB_OUT, PC_OUT;
  logic [7:0] PA_OE, PB_OE, PC_OE;

  int n_run  = 0;
  int n_fail = 0;

  ppi_sync_core #(.SYNC_STAGES(2), .RESET_CW(8'h9B)) dut (
    .CLK(CLK), .RESET(RESET),
    .CS_N(CS_N), .RD_N(RD_N), .WR_N(WR_N),
    .A(A), .DIN(DIN), .DOUT(DOUT), .DOE(DOE),
    .PA_IN(PA_IN), .PB_IN(PB_IN), .PC_IN(PC_IN),
    .PA_OUT(PA_OUT), .PB_OUT(PB_OUT), .PC_OUT(PC_OUT),
    .PA_OE(PA_OE), .PB_OE(PB_OE), .PC_OE(PC_OE)
  );

  always #5 CLK = ~CLK;

  task automatic idle(input int n);
    repeat (n) @(negedge CLK);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [7:0] d);
    @(negedge CLK);
    CS_N = 1'b0; WR_N = 1'b0; A = a; DIN = d;
    @(negedge CLK);
    CS_N = 1'b1; WR_N = 1'b1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [7:0] d,
                          output logic doe);
    @(negedge CLK);
    CS_N = 1'b0; RD_N = 1'b0; A = a;
    @(negedge CLK);
    d = DOUT; doe = DOE;
    CS_N = 1'b1; RD_N = 1'b1;
  endtask

  task automatic test_reset;
    logic [7:0] d;
    logic       e;
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
    n_run++;
    if (DOE !== 1'b0) begin
      n_fail++; $display("FAIL reset_doe got %b exp 0", DOE);
    end
    n_run++;
    if (PA_OE !== 8'h00) begin
      n_fail++; $display("FAIL reset_pa_oe got %h exp 00", PA_OE);
    end
    n_run++;
    if (PB_OE !== 8'h00) begin
      n_fail++; $display("FAIL reset_pb_oe got %h exp 00", PB_OE);
    end
    n_run++;
    if (PC_OE !== 8'h00) begin
      n_fail++; $display("FAIL reset_pc_oe got %h exp 00", PC_OE);
    end
    n_run++;
    if (PC_OUT !== 8'h00) begin
      n_fail++; $display("FAIL reset_pc_out got %h exp 00", PC_OUT);
    end
    bus_read(2'b11, d, e);
    n_run++;
    if (d !== 8'h9B) begin
      n_fail++; $display("FAIL reset_ctrl got %h exp 9b", d);
    end
  endtask

  task automatic test_port_a;
    logic [7:0] d;
    logic       e;
    bus_write(2'b11, 8'h80);
    bus_write(2'b00, 8'h5A);
    n_run++;
    if (PA_OUT !== 8'h5A) begin
      n_fail++; $display("FAIL pa_out got %h exp 5a", PA_OUT);
    end
    n_run++;
    if (PA_OE !== 8'hFF) begin
      n_fail++; $display("FAIL pa_oe got %h exp ff", PA_OE);
    end
    bus_read(2'b00, d, e);
    n_run++;
    if (d !== 8'h5A) begin
      n_fail++; $display("FAIL pa_read got %h exp 5a", d);
    end
    n_run++;
    if (e !== 1'b1) begin
      n_fail++; $display("FAIL doe_during got %b exp 1", e);
    end
    @(negedge CLK);
    n_run++;
    if (DOE !== 1'b0) begin
      n_fail++; $display("FAIL doe_after got %b exp 0", DOE);
    end
    bus_write(2'b11, 8'h80);
    n_run++;
    if (PA_OUT !== 8'h00) begin
      n_fail++; $display("FAIL modeset_clear got %h exp 00", PA_OUT);
    end
  endtask

  task automatic test_bsr;
    logic [7:0] d;
    logic       e;
    bus_write(2'b11, 8'h80);
    bus_write(2'b11, 8'h0B);
    n_run++;
    if (PC_OUT !== 8'h20) begin
      n_fail++; $display("FAIL bsr_set got %h exp 20", PC_OUT);
    end
    bus_write(2'b11, 8'h0A);
    n_run++;
    if (PC_OUT !== 8'h00) begin
      n_fail++; $display("FAIL bsr_clr got %h exp 00", PC_OUT);
    end
    bus_read(2'b11, d, e);
    n_run++;
    if (d !== 8'h80) begin
      n_fail++; $display("FAIL bsr_ctrl got %h exp 80", d);
    end
  endtask

  task automatic test_pc_mask;
    bus_write(2'b11, 8'h81);
    bus_write(2'b10, 8'hFF);
    n_run++;
    if (PC_OUT !== 8'hF0) begin
      n_fail++; $display("FAIL pc_mask_out got %h exp f0", PC_OUT);
    end
    n_run++;
    if (PC_OE !== 8'hF0) begin
      n_fail++; $display("FAIL pc_mask_oe got %h exp f0", PC_OE);
    end
  endtask

  task automatic test_single_strobe;
    bus_write(2'b11, 8'h80);
    @(negedge CLK);
    CS_N = 1'b0; WR_N = 1'b0; A = 2'b01; DIN = 8'h11;
    @(negedge CLK);
    DIN = 8'h22;
    @(negedge CLK);
    DIN = 8'h33;
    @(negedge CLK);
    CS_N = 1'b1; WR_N = 1'b1;
    n_run++;
    if (PB_OUT !== 8'h11) begin
      n_fail++; $display("FAIL one_write got %h exp 11", PB_OUT);
    end
  endtask

  task automatic test_reset_wins;
    logic [7:0] d;
    logic       e;
    @(negedge CLK);
    RESET = 1'b1;
    CS_N = 1'b0; WR_N = 1'b0; A = 2'b11; DIN = 8'h80;
    @(negedge CLK);
    RESET = 1'b0;
    CS_N = 1'b1; WR_N = 1'b1;
    bus_read(2'b11, d, e);
    n_run++;
    if (d !== 8'h9B) begin
      n_fail++; $display("FAIL reset_wins got %h exp 9b", d);
    end
  endtask

  task automatic test_sync;
    logic [7:0] d;
    logic       e;
    bus_write(2'b11, 8'h9B);
    PB_IN = 8'hC3;
    idle(4);
    bus_read(2'b01, d, e);
    n_run++;
    if (d !== 8'hC3) begin
      n_fail++; $display("FAIL pb_read got %h exp c3", d);
    end
    @(negedge CLK);
    CS_N = 1'b0; RD_N = 1'b0; A = 2'b01;
    @(negedge CLK);
    PB_IN = 8'h5A;
    @(negedge CLK);
    n_run++;
    if (DOUT !== 8'hC3) begin
      n_fail++; $display("FAIL sync_edge1 got %h exp c3", DOUT);
    end
    @(negedge CLK);
    n_run++;
    if (DOUT !== 8'hC3) begin
      n_fail++; $display("FAIL sync_edge2 got %h exp c3", DOUT);
    end
    @(negedge CLK);
    n_run++;
    if (DOUT !== 8'h5A) begin
      n_fail++; $display("FAIL sync_edge3 got %h exp 5a", DOUT);
    end
    CS_N = 1'b1; RD_N = 1'b1;
    idle(1);
  endtask

`ifdef PPI_MODE1_EN
  task automatic test_mode1_in;
    logic [7:0] d;
    logic       e;
    PC_IN = 8'hFF;
    PA_IN = 8'h3C;
    idle(4);
    bus_write(2'b11, 8'hB0);
    bus_write(2'b11, 8'h09);
    n_run++;
    if (PC_OE !== 8'hEF) begin
      n_fail++; $display("FAIL m1in_oe got %h exp ef", PC_OE);
    end
    PC_IN[4] = 1'b0;
    idle(4);
    n_run++;
    if (PC_OUT[5] !== 1'b1) begin
      n_fail++; $display("FAIL m1in_ibf got %b exp 1", PC_OUT[5]);
    end
    PC_IN[4] = 1'b1;
    idle(4);
    n_run++;
    if (PC_OUT[3] !== 1'b1) begin
      n_fail++; $display("FAIL m1in_intr got %b exp 1", PC_OUT[3]);
    end
    bus_read(2'b10, d, e);
    n_run++;
    if (d !== 8'h38) begin
      n_fail++; $display("FAIL m1in_pc_read got %h exp 38", d);
    end
    PA_IN = 8'h00;
    idle(3);
    bus_read(2'b00, d, e);
    n_run++;
    if (d !== 8'h3C) begin
      n_fail++; $display("FAIL m1in_pa_read got %h exp 3c", d);
    end
    @(negedge CLK);
    n_run++;
    if (PC_OUT[5] !== 1'b0 || PC_OUT[3] !== 1'b0) begin
      n_fail++; $display("FAIL m1in_clear got ibf=%b intr=%b exp 0 0",
                         PC_OUT[5], PC_OUT[3]);
    end
  endtask

  task automatic test_mode1_out;
    logic [7:0] d;
    logic       e;
    PC_IN = 8'hFF;
    idle(4);
    bus_write(2'b11, 8'hA0);
    bus_write(2'b11, 8'h0D);
    bus_write(2'b00, 8'h77);
    n_run++;
    if (PC_OUT[7] !== 1'b0) begin
      n_fail++; $display("FAIL m1out_obf got %b exp 0", PC_OUT[7]);
    end
    n_run++;
    if (PC_OE !== 8'hBF) begin
      n_fail++; $display("FAIL m1out_oe got %h exp bf", PC_OE);
    end
    PC_IN[6] = 1'b0;
    idle(4);
    n_run++;
    if (PC_OUT[7] !== 1'b1) begin
      n_fail++; $display("FAIL m1out_ack got %b exp 1", PC_OUT[7]);
    end
    PC_IN[6] = 1'b1;
    idle(4);
    n_run++;
    if (PC_OUT[3] !== 1'b1) begin
      n_fail++; $display("FAIL m1out_intr got %b exp 1", PC_OUT[3]);
    end
    bus_write(2'b00, 8'h55);
    n_run++;
    if (PC_OUT[7] !== 1'b0 || PC_OUT[3] !== 1'b0) begin
      n_fail++; $display("FAIL m1out_rewrite got obf=%b intr=%b exp 0 0",
                         PC_OUT[7], PC_OUT[3]);
    end
    PC_IN[6] = 1'b0;
    idle(1);
    RESET = 1'b1;
    idle(2);
    RESET = 1'b0;
    PC_IN[6] = 1'b1;
    idle(4);
    bus_write(2'b11, 8'hA0);
    bus_read(2'b10, d, e);
    n_run++;
    if (d !== 8'h80) begin
      n_fail++; $display("FAIL m1out_reset got %h exp 80", d);
    end
  endtask
`endif

  initial begin
    RESET = 1'b1;
    CS_N = 1'b1; RD_N = 1'b1; WR_N = 1'b1;
    A = 2'b00; DIN = 8'h00;
    PA_IN = 8'h00; PB_IN = 8'h00; PC_IN = 8'hFF;
    test_reset;
    test_port_a;
    test_bsr;
    test_pc_mask;
    test_single_strobe;
    test_reset_wins;
    test_sync;
`ifdef PPI_MODE1_EN
    test_mode1_in;
    test_mode1_out;
`endif
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
